// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer: Wishbone master filling the framebuffer with a grid/colour-field test pattern.
module fb_pattern_writer #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          GRID     = 16,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt,
  output logic        err_flag,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack,
  input  logic        wshb_err,
  input  logic        wshb_rty,
  input  logic [31:0] wshb_dat_sm
);
  localparam int XW = HDISP > 1 ? $clog2(HDISP) : 1;
  localparam int YW = VDISP > 1 ? $clog2(VDISP) : 1;
  localparam int GW = $clog2(GRID);
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;
  state_t      r_state;
  logic        r_act;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_frame;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [31:0] r_adr;
  logic        w_xend;
  logic        w_last;
  logic        w_grid;
  logic [7:0]  w_x8;
  logic [7:0]  w_y8;
  logic        w_unused;
  assign w_xend   = r_x == XW'(HDISP - 1);
  assign w_last   = w_xend && r_y == YW'(VDISP - 1);
  assign w_grid   = r_x[GW-1:0] == '0 || r_y[GW-1:0] == '0;
  assign w_x8     = 8'(r_x);
  assign w_y8     = 8'(r_y);
  assign w_unused = ^{wshb_dat_sm, wshb_rty};
  // rty needs no action: address and data simply hold until ack or err
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_act   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_frame <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_adr   <= BASE_ADR;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (start || continuous) begin
            r_state <= S_WRITE;
            r_act   <= 1'b1;
          end
        S_WRITE:
          if (wshb_err) begin
            r_err   <= 1'b1;
            r_act   <= 1'b0;
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_adr   <= BASE_ADR;
          end else if (wshb_ack) begin
            r_x   <= w_xend ? '0 : r_x + 1'b1;
            r_y   <= w_last ? '0 : w_xend ? r_y + 1'b1 : r_y;
            r_adr <= w_last ? BASE_ADR : r_adr + 32'd4;
            if (w_last) begin
              r_state <= S_GAP;
              r_act   <= 1'b0;
              r_done  <= 1'b1;
              r_frame <= r_frame + 8'd1;
            end
          end
        S_GAP: begin
          r_state <= continuous ? S_WRITE : S_IDLE;
          r_act   <= continuous;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign busy        = r_act;
  assign done        = r_done;
  assign frame_cnt   = r_frame;
  assign err_flag    = r_err;
  assign wshb_cyc    = r_act;
  assign wshb_stb    = r_act;
  assign wshb_we     = 1'b1;
  assign wshb_adr    = r_adr;
  assign wshb_dat_ms = w_grid ? 32'h00FF_FFFF : {8'h00, w_x8 ^ r_frame, w_y8, r_frame};
  assign wshb_sel    = 4'b1111;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;
endmodule
